// File: rtl/uart_pkg.sv
// Shared types, legal parameter ranges and the parity helper for the UART blocks.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam int DATA_BITS_MIN    = 5;
   localparam int DATA_BITS_MAX    = 9;
   localparam int STOP_BITS_MIN    = 1;
   localparam int STOP_BITS_MAX    = 2;
   localparam int CLKS_PER_BIT_MIN = 2;
   localparam int CLKS_PER_BIT_MAX = 16383;

   // Parity over a zero-extended payload; extra zero bits leave the XOR unchanged.
   function automatic logic par(input logic [DATA_BITS_MAX-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divisor: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit time.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_count;

   // Free-running divisor; clear restarts the bit time from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear || (r_count == LAST)) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign tick = (r_count == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one-deep holding register, frame FSM with shifter, registered line output.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   // Reject configurations the datapath was not sized for.
   if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS=%0d outside %0d..%0d", DATA_BITS, DATA_BITS_MIN, DATA_BITS_MAX);
   end
   if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS=%0d outside %0d..%0d", STOP_BITS, STOP_BITS_MIN, STOP_BITS_MAX);
   end
   if (CLKS_PER_BIT < CLKS_PER_BIT_MIN || CLKS_PER_BIT > CLKS_PER_BIT_MAX) begin : g_bad_clks
      $error("uart_tx_frame: CLKS_PER_BIT=%0d outside %0d..%0d", CLKS_PER_BIT, CLKS_PER_BIT_MIN, CLKS_PER_BIT_MAX);
   end
   if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
      $error("uart_tx_frame: PARITY_EN=%0d must be 0 or 1", PARITY_EN);
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
      $error("uart_tx_frame: PARITY_ODD=%0d must be 0 or 1", PARITY_ODD);
   end

   localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP_IDX = 4'(STOP_BITS - 1);
   localparam logic       ODD_SEL       = (PARITY_ODD != 0);

   tx_state_t              r_state;
   logic                   r_tx;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_parity;
   logic [3:0]             r_bit_idx;
   logic                   r_hold_full;
   logic [DATA_BITS-1:0]   r_hold_data;

   logic                   w_tick;
   logic                   w_clear;
   logic                   w_last_data;
   logic                   w_last_stop;
   logic                   w_frame_end;
   logic                   w_accept;
   logic                   w_load;
   logic [DATA_BITS_MAX-1:0] w_hold_ext;

   assign w_last_data = (r_bit_idx == LAST_DATA_IDX);
   assign w_last_stop = (r_bit_idx == LAST_STOP_IDX);
   assign w_frame_end = (r_state == STOP) && w_tick && w_last_stop;
   assign w_accept    = in_valid && !r_hold_full;
   // The shifter takes the held byte either from idle or straight out of the last stop bit.
   assign w_load      = r_hold_full && ((r_state == IDLE) || w_frame_end);
   assign w_hold_ext  = DATA_BITS_MAX'(r_hold_data);

   // Restart the bit time whenever the FSM changes state; idle keeps it parked at zero.
   assign w_clear = (r_state == IDLE)
                 || (w_tick && ((r_state == START) || (r_state == PARITY)
                                || ((r_state == DATA) && w_last_data)
                                || ((r_state == STOP) && w_last_stop)));

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (w_clear),
      .tick  (w_tick)
   );

   // Holding register: fills on a handshake, empties when the shifter loads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold_full <= 1'b0;
         r_hold_data <= '0;
      end else if (w_accept) begin
         r_hold_full <= 1'b1;
         r_hold_data <= in_data;
      end else if (w_load) begin
         r_hold_full <= 1'b0;
      end
   end

   // Frame sequencer, shifter and registered line driver.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_tx      <= 1'b1;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_bit_idx <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_tx <= 1'b1;
               if (w_load) begin
                  r_state   <= START;
                  r_tx      <= 1'b0;
                  r_shift   <= r_hold_data;
                  r_parity  <= par(w_hold_ext, ODD_SEL);
                  r_bit_idx <= '0;
               end
            end
            START: begin
               if (w_tick) begin
                  r_state   <= DATA;
                  r_tx      <= r_shift[0];
                  r_bit_idx <= '0;
               end
            end
            DATA: begin
               if (w_tick) begin
                  if (w_last_data) begin
                     r_bit_idx <= '0;
                     if (PARITY_EN != 0) begin
                        r_state <= PARITY;
                        r_tx    <= r_parity;
                     end else begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                     end
                  end else begin
                     r_shift   <= r_shift >> 1;
                     r_tx      <= r_shift[1];
                     r_bit_idx <= r_bit_idx + 4'd1;
                  end
               end
            end
            PARITY: begin
               if (w_tick) begin
                  r_state   <= STOP;
                  r_tx      <= 1'b1;
                  r_bit_idx <= '0;
               end
            end
            STOP: begin
               if (w_tick) begin
                  if (w_last_stop) begin
                     r_bit_idx <= '0;
                     if (w_load) begin
                        r_state  <= START;
                        r_tx     <= 1'b0;
                        r_shift  <= r_hold_data;
                        r_parity <= par(w_hold_ext, ODD_SEL);
                     end else begin
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                     end
                  end else begin
                     r_bit_idx <= r_bit_idx + 4'd1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   assign tx       = r_tx;
   assign busy     = (r_state != IDLE);
   assign tx_done  = w_frame_end;
   assign in_ready = !r_hold_full;

endmodule
